// File: rtl/clks_alot_pkg.sv
// clks_alot_p: shared link parameters, interface word and transmit-side types
package clks_alot_p;
   localparam int SYS_CLOCK_MULTIPLE            = 64;
   localparam int TRANSMITTED_BITS              = 16;
   localparam int CYCLES_PER_BIT                = 2;
   localparam int SHORT_PAUSE_CYCLE_COUNT       = 6;
   localparam int LONG_PAUSE_CYCLE_COUNT        = 60;
   localparam int TARGET_EDGE_CYCLE_COUNT       = SYS_CLOCK_MULTIPLE / 2;
   localparam int TARGET_SHORT_LENGTH           = SHORT_PAUSE_CYCLE_COUNT * SYS_CLOCK_MULTIPLE;
   localparam int TARGET_LONG_LENGTH            = LONG_PAUSE_CYCLE_COUNT * SYS_CLOCK_MULTIPLE;
   localparam int NEGEDGES_BETWEEN_SHORT_PAUSES = TRANSMITTED_BITS * CYCLES_PER_BIT;
   localparam int CYCLE_BITWIDTH                = $clog2(TARGET_EDGE_CYCLE_COUNT);
   localparam int NEGEDGE_BITWIDTH              = $clog2(NEGEDGES_BETWEEN_SHORT_PAUSES);
   localparam int PAUSE_COUNTER_WIDTH           = $clog2(TARGET_LONG_LENGTH);
   localparam int INTERFACE_WIDTH               = 4;
   typedef struct packed {
      logic clk;
      logic addr;
      logic data_high;
      logic data_low;
   } interface_s;
   typedef enum logic [1:0] {IDLE, FRAME, SHORT_PAUSE, LONG_PAUSE} tx_state_e;
   typedef struct packed {
      logic                        addr;
      logic [TRANSMITTED_BITS-1:0] data_high;
      logic [TRANSMITTED_BITS-1:0] data_low;
   } tx_word_s;
   typedef struct packed {
      logic rise;
      logic fall;
   } clock_events_s;
endpackage

// File: rtl/clks_alot_tx_clkgen.sv
// clks_alot_tx_clkgen: link-clock divider; strobes flag the edge being driven this cycle
module clks_alot_tx_clkgen
   import clks_alot_p::*;
(
   input  logic          sys_clk,
   input  logic          sync_rst,
   input  logic          run,
   output logic          level,
   output clock_events_s ev
);
   logic [CYCLE_BITWIDTH-1:0] cnt;
   logic wrap;
   // a half period ends when the counter reaches its last value while running
   always_comb begin
      wrap    = run && cnt == CYCLE_BITWIDTH'(TARGET_EDGE_CYCLE_COUNT - 1);
      ev.rise = wrap && !level;
      ev.fall = wrap && level;
   end
   // half-period counter and clock level, held low and cleared while stopped
   always_ff @(posedge sys_clk) begin
      if (sync_rst || !run) begin
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         cnt   <= wrap ? '0 : cnt + CYCLE_BITWIDTH'(1);
         level <= level ^ wrap;
      end
   end
endmodule

// File: rtl/clks_alot_tx.sv
// clks_alot_tx: serialises 2x16-bit words onto the clks_alot link with framing pauses
module clks_alot_tx
   import clks_alot_p::*;
(
   input  logic                          sys_clk,
   input  logic                          sync_rst,
   input  logic                          tx_enable,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_addr,
   input  logic [2*TRANSMITTED_BITS-1:0] in_data,
   output interface_s                    tx_if,
   output logic                          busy,
   output logic                          pause_active,
   output logic                          frame_done
);
   tx_state_e                     state;
   tx_word_s                      hold;
   logic                          hold_valid;
   logic [TRANSMITTED_BITS-2:0]   sh_high, sh_low;
   logic [NEGEDGE_BITWIDTH:0]     neg_cnt;
   logic [PAUSE_COUNTER_WIDTH-1:0] pause_cnt;
   logic                          level;
   clock_events_s                 ev;
   logic                          accept, load, last_fall, shift, short_end, long_end;

   clks_alot_tx_clkgen u_clkgen (
      .sys_clk  (sys_clk),
      .sync_rst (sync_rst),
      .run      (state == FRAME),
      .level    (level),
      .ev       (ev)
   );

   // handshake, frame-boundary and pause-expiry decodes
   always_comb begin
      accept       = in_valid && !hold_valid;
      short_end    = state == SHORT_PAUSE && pause_cnt == PAUSE_COUNTER_WIDTH'(TARGET_SHORT_LENGTH - 1);
      long_end     = state == LONG_PAUSE && pause_cnt == PAUSE_COUNTER_WIDTH'(TARGET_LONG_LENGTH - 1);
      load         = (state == IDLE || short_end) && hold_valid && tx_enable;
      last_fall    = ev.fall && neg_cnt == (NEGEDGE_BITWIDTH + 1)'(NEGEDGES_BETWEEN_SHORT_PAUSES - 1);
      shift        = ev.fall && neg_cnt[0];
      in_ready     = !hold_valid;
      busy         = state != IDLE;
      pause_active = state == SHORT_PAUSE || state == LONG_PAUSE;
   end

   // holding register: filled on accept, freed on the cycle the shifter takes it
   always_ff @(posedge sys_clk) begin
      if (sync_rst) begin
         hold_valid <= 1'b0;
         hold       <= '0;
      end else if (load) begin
         hold_valid <= 1'b0;
      end else if (accept) begin
         hold_valid <= 1'b1;
         hold       <= {in_addr, in_data};
      end
   end

   // framing FSM with shifter, edge/pause counters and registered link outputs
   always_ff @(posedge sys_clk) begin
      if (sync_rst) begin
         state      <= IDLE;
         sh_high    <= '0;
         sh_low     <= '0;
         neg_cnt    <= '0;
         pause_cnt  <= '0;
         tx_if      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (load) begin
            state     <= FRAME;
            sh_high   <= hold.data_high[TRANSMITTED_BITS-2:0];
            sh_low    <= hold.data_low[TRANSMITTED_BITS-2:0];
            neg_cnt   <= '0;
            pause_cnt <= '0;
            tx_if     <= {1'b0, hold.addr, hold.data_high[TRANSMITTED_BITS-1], hold.data_low[TRANSMITTED_BITS-1]};
         end else begin
            case (state)
               FRAME: begin
                  if (last_fall) begin
                     state      <= SHORT_PAUSE;
                     neg_cnt    <= '0;
                     tx_if      <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     tx_if.clk <= level ^ (ev.rise | ev.fall);
                     if (ev.fall) neg_cnt <= neg_cnt + (NEGEDGE_BITWIDTH + 1)'(1);
                     if (shift) begin
                        sh_high         <= {sh_high[TRANSMITTED_BITS-3:0], 1'b0};
                        sh_low          <= {sh_low[TRANSMITTED_BITS-3:0], 1'b0};
                        tx_if.data_high <= sh_high[TRANSMITTED_BITS-2];
                        tx_if.data_low  <= sh_low[TRANSMITTED_BITS-2];
                     end
                  end
               end
               SHORT_PAUSE: begin
                  state     <= short_end ? LONG_PAUSE : SHORT_PAUSE;
                  pause_cnt <= short_end ? '0 : pause_cnt + PAUSE_COUNTER_WIDTH'(1);
               end
               LONG_PAUSE: begin
                  state     <= long_end ? IDLE : LONG_PAUSE;
                  pause_cnt <= long_end ? '0 : pause_cnt + PAUSE_COUNTER_WIDTH'(1);
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_clks_alot_tx.sv
// tb_clks_alot_tx: directed scenarios with a frame-decoding monitor and word scoreboard
module tb_clks_alot_tx;
   import clks_alot_p::*;

   logic        sys_clk = 1'b0;
   logic        sync_rst = 1'b1;
   logic        tx_enable = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_addr = 1'b0;
   logic [31:0] in_data = '0;
   interface_s  tx_if;
   logic        busy, pause_active, frame_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [32:0] sb[$];

   clks_alot_tx dut (
      .sys_clk      (sys_clk),
      .sync_rst     (sync_rst),
      .tx_enable    (tx_enable),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_addr      (in_addr),
      .in_data      (in_data),
      .tx_if        (tx_if),
      .busy         (busy),
      .pause_active (pause_active),
      .frame_done   (frame_done)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor state
   logic        prev_clk = 1'b0, prev_in_frame = 1'b0, tracking = 1'b0, fa = 1'b0;
   logic [15:0] hi = '0, lo = '0;
   int nr = 0, nf = 0, last_edge = 0, entry_cyc = 0, last_fall_cyc = 0;
   int last_gap = 0, pause_len = 0, last_pause_len = 0;

   always @(negedge sys_clk) begin
      logic in_f, fd_exp, rose, fell;
      in_f   = busy && !pause_active;
      fd_exp = 1'b0;
      rose   = tx_if.clk && !prev_clk;
      fell   = !tx_if.clk && prev_clk;
      if (sync_rst) begin
         tracking  = 1'b0;
         pause_len = 0;
      end else begin
         if (in_f && !prev_in_frame) begin
            tracking  = 1'b1;
            nr = 0; nf = 0; hi = '0; lo = '0;
            last_edge = cyc; entry_cyc = cyc; fa = tx_if.addr;
         end
         if (in_f) chk("addr_hold", tx_if.addr, fa);
         else chk("lines_idle", tx_if, 4'h0);
         if (tracking && rose) begin
            chk("rise_spacing", cyc - last_edge, 32);
            nr++;
            if (nr == 1) last_gap = cyc - last_fall_cyc;
            if (nr % 2 == 1) begin
               hi = {hi[14:0], tx_if.data_high};
               lo = {lo[14:0], tx_if.data_low};
            end else begin
               chk("bit_stable", {tx_if.data_high, tx_if.data_low}, {hi[0], lo[0]});
            end
            last_edge = cyc;
         end
         if (tracking && fell) begin
            chk("fall_spacing", cyc - last_edge, 32);
            nf++;
            last_edge = cyc;
            if (nf == 32) begin
               fd_exp = 1'b1;
               chk("frame_len", cyc - entry_cyc, 2048);
               chk("rise_count", nr, 32);
               chk("sb_nonempty", sb.size() > 0, 1);
               if (sb.size() > 0) chk("frame_word", {fa, hi, lo}, sb.pop_front());
               last_fall_cyc = cyc;
               tracking = 1'b0;
            end
         end
         chk("frame_done", frame_done, fd_exp);
         if (pause_active) pause_len++;
         else if (pause_len != 0) begin
            last_pause_len = pause_len;
            pause_len = 0;
         end
      end
      prev_clk      = tx_if.clk;
      prev_in_frame = in_f;
   end

   task automatic offer(input logic a, input logic [31:0] d);
      logic acc;
      int n;
      in_addr = a; in_data = d; in_valid = 1'b1; acc = 1'b0; n = 0;
      while (!acc && n < 10000) begin
         acc = in_ready;
         @(posedge sys_clk); #1;
         n++;
      end
      in_valid = 1'b0;
      chk("accept", acc, 1);
      if (acc) sb.push_back({a, d});
   endtask

   // what: 0 = frame_done, 1 = idle, 2 = frame running
   task automatic wait_ev(input int what, input int bound, input string tag);
      logic ok;
      int n;
      ok = 1'b0; n = 0;
      while (!ok && n < bound) begin
         @(negedge sys_clk);
         ok = what == 0 ? frame_done : what == 1 ? !busy : (busy && !pause_active);
         n++;
      end
      #1;
      chk(tag, ok, 1);
   endtask

   initial begin
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_tx_if", tx_if, 4'h0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_pause", pause_active, 0);
      chk("rst_done", frame_done, 0);
      sync_rst = 1'b0;
      tx_enable = 1'b1;

      // single word
      offer(1'b0, 32'hA5A5_3C3C);
      wait_ev(0, 3000, "single_done");
      wait_ev(1, 5000, "single_idle");
      chk("single_pause", last_pause_len, 4224);

      // back-to-back
      offer(1'b0, 32'h1234_8001);
      offer(1'b0, 32'h0F0F_F0F0);
      chk("b2b_ready_full", in_ready, 0);
      wait_ev(0, 3000, "b2b_done1");
      chk("b2b_ready_pause", in_ready, 0);
      wait_ev(2, 1000, "b2b_frame2");
      chk("b2b_ready_load", in_ready, 1);
      chk("b2b_short_only", last_pause_len, 384);
      wait_ev(0, 3000, "b2b_done2");
      chk("b2b_gap", last_gap, 416);
      wait_ev(1, 5000, "b2b_idle");
      chk("b2b_pause2", last_pause_len, 4224);

      // address frame
      offer(1'b1, 32'hFFFF_0000);
      wait_ev(0, 3000, "addr_done");
      chk("addr_after", tx_if.addr, 0);
      wait_ev(1, 5000, "addr_idle");

      // backpressure, three words
      offer(1'b0, 32'h0000_0001);
      offer(1'b1, 32'h8000_7FFE);
      chk("bp_full", in_ready, 0);
      offer(1'b0, 32'hDEAD_BEEF);
      chk("bp_full2", in_ready, 0);
      wait_ev(0, 3000, "bp_done2");
      wait_ev(0, 3000, "bp_done3");
      wait_ev(1, 5000, "bp_idle");

      // reset mid-frame
      offer(1'b0, 32'h5555_AAAA);
      wait_ev(2, 100, "rst_frame");
      repeat (700) @(posedge sys_clk);
      #1 sync_rst = 1'b1;
      sb.delete();
      @(posedge sys_clk); #1;
      sync_rst = 1'b0;
      chk("abort_tx_if", tx_if, 4'h0);
      chk("abort_busy", busy, 0);
      chk("abort_ready", in_ready, 1);
      offer(1'b1, 32'hC3C3_1E1E);
      wait_ev(0, 3000, "clean_done");
      wait_ev(1, 5000, "clean_idle");

      // tx_enable dropped mid-frame with hold full
      offer(1'b0, 32'h0123_4567);
      offer(1'b0, 32'h89AB_CDEF);
      tx_enable = 1'b0;
      wait_ev(0, 3000, "en_done");
      wait_ev(1, 5000, "en_idle");
      chk("en_long", last_pause_len, 4224);
      chk("en_hold", in_ready, 0);
      repeat (20) @(posedge sys_clk);
      #1;
      chk("en_stay_idle", busy, 0);
      tx_enable = 1'b1;
      @(posedge sys_clk); #1;
      chk("en_start", busy && !pause_active, 1);
      wait_ev(0, 3000, "en_done2");
      wait_ev(1, 5000, "en_idle2");
      chk("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
